// File: rtl/result_scoreboard.sv
// In-order result scoreboard: golden results queue in a FIFO and each DUT
// result is compared against the head, with counters, sticky flags and first-failure capture.
module result_scoreboard #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iClear,
  input  logic                     iExp_Valid,
  input  logic [WIDTH-1:0]         iExp_Data,
  output logic                     oExp_Ready,
  input  logic                     iDut_Valid,
  input  logic [WIDTH-1:0]         iDut_Data,
  output logic                     oMatch,
  output logic                     oMismatch,
  output logic                     oGood,
  output logic [CNT_W-1:0]         oPass_Count,
  output logic [CNT_W-1:0]         oFail_Count,
  output logic [$clog2(DEPTH):0]   oPending,
  output logic                     oOverflow,
  output logic                     oUnderflow,
  output logic                     oHalted,
  output logic [WIDTH-1:0]         oFirst_Exp,
  output logic [WIDTH-1:0]         oFirst_Got
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic               match_q, match_d;
  logic               mismatch_q, mismatch_d;
  logic               good_q, good_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               first_seen_q, first_seen_d;
  logic [WIDTH-1:0]   first_exp_q, first_exp_d;
  logic [WIDTH-1:0]   first_got_q, first_got_d;

  logic full, empty, push, pop, flush;
  logic [WIDTH-1:0] head;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign flush = !Reset || iClear;
  // Occupancy is sampled before this edge, so a same-cycle pop never frees a slot for a push.
  assign push  = iExp_Valid && !full;
  assign pop   = iDut_Valid && !empty && (state_q == RUN);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    match_d      = 1'b0;
    mismatch_d   = 1'b0;
    good_d       = good_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    first_seen_d = first_seen_q;
    first_exp_d  = first_exp_q;
    first_got_d  = first_got_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (iExp_Valid && full) begin
      ovf_d  = 1'b1;
      good_d = 1'b0;
    end
    // No bypass: an empty FIFO underflows even if a push lands in the same cycle.
    if (iDut_Valid && empty && (state_q == RUN)) begin
      unf_d  = 1'b1;
      good_d = 1'b0;
    end

    if (pop) begin
      if (iDut_Data == head) begin
        match_d = 1'b1;
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end else begin
        mismatch_d = 1'b1;
        good_d     = 1'b0;
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        if (!first_seen_q) begin
          first_seen_d = 1'b1;
          first_exp_d  = head;
          first_got_d  = iDut_Data;
        end
        if (STOP_ON_FAIL == 1) state_d = HALT;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (flush) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      match_q      <= 1'b0;
      mismatch_q   <= 1'b0;
      good_q       <= 1'b1;
      pass_q       <= '0;
      fail_q       <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      first_seen_q <= 1'b0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      mismatch_q   <= mismatch_d;
      good_q       <= good_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      first_seen_q <= first_seen_d;
      first_exp_q  <= first_exp_d;
      first_got_q  <= first_got_d;
    end
  end

  // Storage needs no reset; pointers and occupancy define which entries are live.
  always_ff @(posedge Clock) begin
    if (!flush && push) mem_q[wr_ptr_q] <= iExp_Data;
  end

  assign oExp_Ready  = !full;
  assign oMatch      = match_q;
  assign oMismatch   = mismatch_q;
  assign oGood       = good_q;
  assign oPass_Count = pass_q;
  assign oFail_Count = fail_q;
  assign oPending    = cnt_q;
  assign oOverflow   = ovf_q;
  assign oUnderflow  = unf_q;
  assign oHalted     = (state_q == HALT);
  assign oFirst_Exp  = first_exp_q;
  assign oFirst_Got  = first_got_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard: instance A (CNT_W=4, free-running) and
// instance B (STOP_ON_FAIL=1) share one stimulus stream.
module tb_result_scoreboard;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iClear = 1'b0;
  logic        iExp_Valid = 1'b0;
  logic [63:0] iExp_Data = '0;
  logic        iDut_Valid = 1'b0;
  logic [63:0] iDut_Data = '0;

  logic        a_ready, a_match, a_mismatch, a_good, a_ovf, a_unf, a_halted;
  logic [3:0]  a_pass, a_fail;
  logic [3:0]  a_pend;
  logic [63:0] a_fexp, a_fgot;

  logic        b_ready, b_match, b_mismatch, b_good, b_ovf, b_unf, b_halted;
  logic [15:0] b_pass, b_fail;
  logic [3:0]  b_pend;
  logic [63:0] b_fexp, b_fgot;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  result_scoreboard #(.WIDTH(64), .DEPTH(8), .CNT_W(4), .STOP_ON_FAIL(0)) ua (
    .Clock(Clock), .Reset(Reset), .iClear(iClear),
    .iExp_Valid(iExp_Valid), .iExp_Data(iExp_Data), .oExp_Ready(a_ready),
    .iDut_Valid(iDut_Valid), .iDut_Data(iDut_Data),
    .oMatch(a_match), .oMismatch(a_mismatch), .oGood(a_good),
    .oPass_Count(a_pass), .oFail_Count(a_fail), .oPending(a_pend),
    .oOverflow(a_ovf), .oUnderflow(a_unf), .oHalted(a_halted),
    .oFirst_Exp(a_fexp), .oFirst_Got(a_fgot));

  result_scoreboard #(.WIDTH(64), .DEPTH(8), .CNT_W(16), .STOP_ON_FAIL(1)) ub (
    .Clock(Clock), .Reset(Reset), .iClear(iClear),
    .iExp_Valid(iExp_Valid), .iExp_Data(iExp_Data), .oExp_Ready(b_ready),
    .iDut_Valid(iDut_Valid), .iDut_Data(iDut_Data),
    .oMatch(b_match), .oMismatch(b_mismatch), .oGood(b_good),
    .oPass_Count(b_pass), .oFail_Count(b_fail), .oPending(b_pend),
    .oOverflow(b_ovf), .oUnderflow(b_unf), .oHalted(b_halted),
    .oFirst_Exp(b_fexp), .oFirst_Got(b_fgot));

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear();
    iClear = 1'b1; step(); iClear = 1'b0;
  endtask

  task automatic push(input logic [63:0] v);
    iExp_Valid = 1'b1; iExp_Data = v; step(); iExp_Valid = 1'b0;
  endtask

  task automatic dut(input logic [63:0] v);
    iDut_Valid = 1'b1; iDut_Data = v; step(); iDut_Valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; step(); step(); Reset = 1'b1; step();
    n_cmp++; if (a_good !== 1'b1) begin n_fail++; $display("FAIL reset_good got=%b want=1", a_good); end
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    n_cmp++; if (a_pend !== 4'd0) begin n_fail++; $display("FAIL reset_pending got=%0d want=0", a_pend); end
    n_cmp++; if ({a_pass, a_fail} !== 8'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d want=0/0", a_pass, a_fail); end
    n_cmp++; if ({a_ovf, a_unf, a_halted, a_match, a_mismatch} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=00000", {a_ovf, a_unf, a_halted, a_match, a_mismatch}); end
  endtask

  task automatic test_in_order();
    logic [63:0] vals [3] = '{64'd3, 64'd7, 64'd12};
    do_clear();
    for (int i = 0; i < 3; i++) push(vals[i]);
    n_cmp++; if (a_pend !== 4'd3) begin n_fail++; $display("FAIL inorder_pending3 got=%0d want=3", a_pend); end
    for (int i = 0; i < 3; i++) begin
      iDut_Valid = 1'b1; iDut_Data = vals[i]; step();
      n_cmp++; if ({a_match, a_mismatch} !== 2'b10) begin
        n_fail++; $display("FAIL inorder_pulse%0d got=%b want=10", i, {a_match, a_mismatch}); end
    end
    iDut_Valid = 1'b0; step();
    n_cmp++; if (a_match !== 1'b0) begin n_fail++; $display("FAIL inorder_pulse_end got=%b want=0", a_match); end
    n_cmp++; if (a_pass !== 4'd3) begin n_fail++; $display("FAIL inorder_pass got=%0d want=3", a_pass); end
    n_cmp++; if (a_pend !== 4'd0) begin n_fail++; $display("FAIL inorder_pending got=%0d want=0", a_pend); end
    n_cmp++; if (a_good !== 1'b1) begin n_fail++; $display("FAIL inorder_good got=%b want=1", a_good); end
  endtask

  task automatic test_halt();
    do_clear();
    push(64'd5); push(64'd9);
    dut(64'd6);
    n_cmp++; if (b_mismatch !== 1'b1) begin n_fail++; $display("FAIL halt_mismatch got=%b want=1", b_mismatch); end
    n_cmp++; if (b_fail !== 16'd1) begin n_fail++; $display("FAIL halt_failcnt got=%0d want=1", b_fail); end
    n_cmp++; if (b_fexp !== 64'd5) begin n_fail++; $display("FAIL halt_first_exp got=%0d want=5", b_fexp); end
    n_cmp++; if (b_fgot !== 64'd6) begin n_fail++; $display("FAIL halt_first_got got=%0d want=6", b_fgot); end
    n_cmp++; if ({b_halted, b_good} !== 2'b10) begin n_fail++; $display("FAIL halt_state got=%b want=10", {b_halted, b_good}); end
    dut(64'd9);
    n_cmp++; if ({b_match, b_mismatch} !== 2'b00) begin n_fail++; $display("FAIL halt_ignored_pulse got=%b want=00", {b_match, b_mismatch}); end
    n_cmp++; if (b_pend !== 4'd1) begin n_fail++; $display("FAIL halt_pending got=%0d want=1", b_pend); end
    n_cmp++; if (b_pass !== 16'd0) begin n_fail++; $display("FAIL halt_pass got=%0d want=0", b_pass); end
    do_clear();
    n_cmp++; if ({b_pend, b_halted, b_good} !== 6'b0000_01) begin
      n_fail++; $display("FAIL halt_clear got=%0d/%b/%b want=0/0/1", b_pend, b_halted, b_good); end
    n_cmp++; if (b_fexp !== 64'd0) begin n_fail++; $display("FAIL halt_clear_fexp got=%0d want=0", b_fexp); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 9; i++) push(64'd100 + 64'(i));
    n_cmp++; if (a_pend !== 4'd8) begin n_fail++; $display("FAIL ovf_pending got=%0d want=8", a_pend); end
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got=%b want=0", a_ready); end
    n_cmp++; if ({a_ovf, a_good} !== 2'b10) begin n_fail++; $display("FAIL ovf_flags got=%b want=10", {a_ovf, a_good}); end
    for (int i = 0; i < 8; i++) dut(64'd100 + 64'(i));
    n_cmp++; if (a_pass !== 4'd8) begin n_fail++; $display("FAIL ovf_pass got=%0d want=8", a_pass); end
    n_cmp++; if ({a_fail, a_pend} !== 8'd0) begin n_fail++; $display("FAIL ovf_drain got=%0d/%0d want=0/0", a_fail, a_pend); end
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_after got=%b want=1", a_ready); end
  endtask

  task automatic test_no_bypass();
    do_clear();
    iExp_Valid = 1'b1; iExp_Data = 64'd4; iDut_Valid = 1'b1; iDut_Data = 64'd4;
    step();
    iExp_Valid = 1'b0; iDut_Valid = 1'b0;
    n_cmp++; if ({a_unf, a_good} !== 2'b10) begin n_fail++; $display("FAIL nobyp_unf got=%b want=10", {a_unf, a_good}); end
    n_cmp++; if ({a_match, a_mismatch} !== 2'b00) begin n_fail++; $display("FAIL nobyp_pulse got=%b want=00", {a_match, a_mismatch}); end
    n_cmp++; if (a_pend !== 4'd1) begin n_fail++; $display("FAIL nobyp_pending got=%0d want=1", a_pend); end
    dut(64'd4);
    n_cmp++; if ({a_match, a_pass, a_pend} !== {1'b1, 4'd1, 4'd0}) begin
      n_fail++; $display("FAIL nobyp_followup got=%b/%0d/%0d want=1/1/0", a_match, a_pass, a_pend); end
  endtask

  task automatic test_saturate_and_reset();
    do_clear();
    for (int k = 1; k <= 20; k++) begin
      push(64'(k));
      dut(64'(k + 1000));
    end
    n_cmp++; if (a_fail !== 4'd15) begin n_fail++; $display("FAIL sat_fail got=%0d want=15", a_fail); end
    n_cmp++; if (a_fexp !== 64'd1) begin n_fail++; $display("FAIL sat_first_exp got=%0d want=1", a_fexp); end
    n_cmp++; if (a_fgot !== 64'd1001) begin n_fail++; $display("FAIL sat_first_got got=%0d want=1001", a_fgot); end
    n_cmp++; if ({a_pass, a_pend, a_halted} !== 9'd0) begin
      n_fail++; $display("FAIL sat_other got=%0d/%0d/%b want=0/0/0", a_pass, a_pend, a_halted); end
    push(64'd50);
    Reset = 1'b0; iExp_Valid = 1'b1; iExp_Data = 64'd77; iDut_Valid = 1'b1; iDut_Data = 64'd0;
    step();
    n_cmp++; if ({a_pend, a_ready, a_good} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid_fifo got=%0d/%b/%b want=0/1/1", a_pend, a_ready, a_good); end
    n_cmp++; if ({a_pass, a_fail} !== 8'd0) begin n_fail++; $display("FAIL rst_mid_counts got=%0d/%0d want=0/0", a_pass, a_fail); end
    n_cmp++; if ({a_ovf, a_unf, a_match, a_mismatch} !== 4'b0) begin
      n_fail++; $display("FAIL rst_mid_flags got=%b want=0000", {a_ovf, a_unf, a_match, a_mismatch}); end
    n_cmp++; if ({a_fexp, a_fgot} !== 128'd0) begin n_fail++; $display("FAIL rst_mid_first got=%0d/%0d want=0/0", a_fexp, a_fgot); end
    n_cmp++; if ({b_halted, b_pend, b_ovf} !== 6'd0) begin
      n_fail++; $display("FAIL rst_mid_b got=%b/%0d/%b want=0/0/0", b_halted, b_pend, b_ovf); end
    Reset = 1'b1; iExp_Valid = 1'b0; iDut_Valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_halt();
    test_overflow();
    test_no_bypass();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_scoreboard.md
Name: result_scoreboard

Overview:
- Parametrised, synthesizable successor to the single-result DUT/model comparator used in the multiplier benches.
- Golden-model results are queued in an in-order expected FIFO. Each DUT result is compared against the FIFO head, so the DUT and the model no longer need equal latency.
- Keeps pass/fail counters, sticky protocol-error flags and a first-failure capture.
- Optionally halts checking on the first mismatch.
- Sits between the behavioural model and the DUT in every arithmetic-unit bench; also usable as an on-chip BIST checker.

Parameters:
- WIDTH, 64, bit width of compared results
- DEPTH, 8, expected-FIFO entries; power of two, at least 2
- CNT_W, 16, width of the pass and fail counters
- STOP_ON_FAIL, 0, 1 = enter HALT after the first mismatch

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- iClear  in  1  synchronous flush of FIFO, counters, flags and capture; resumes RUN
- iExp_Valid  in  1  golden result present
- iExp_Data  in  WIDTH  golden result
- oExp_Ready  out  1  FIFO not full
- iDut_Valid  in  1  DUT result present
- iDut_Data  in  WIDTH  DUT result
- oMatch  out  1  one-cycle pulse: last compare equal
- oMismatch  out  1  one-cycle pulse: last compare differed
- oGood  out  1  high while no mismatch, overflow or underflow since reset/clear
- oPass_Count  out  CNT_W  saturating count of matches
- oFail_Count  out  CNT_W  saturating count of mismatches
- oPending  out  log2(DEPTH)+1  FIFO occupancy
- oOverflow  out  1  sticky: push attempted while full
- oUnderflow  out  1  sticky: DUT result arrived while FIFO empty
- oHalted  out  1  state == HALT
- oFirst_Exp  out  WIDTH  expected value of the first mismatch
- oFirst_Got  out  WIDTH  DUT value of the first mismatch

Behaviour:
- Reset (Reset==0 at a rising edge) and iClear==1 do the same thing:
  - FIFO emptied; oPending=0, oExp_Ready=1
  - all counters, pulses and flags 0; oGood=1; oHalted=0
  - oFirst_Exp=0, oFirst_Got=0; state=RUN
- Reset has priority over iClear. Both have priority over every same-cycle valid, which is ignored.
- FSM states: RUN and HALT.
  - RUN→HALT when a mismatch is registered and STOP_ON_FAIL==1.
  - HALT→RUN only on iClear or Reset.
  - With STOP_ON_FAIL==0, HALT is unreachable.
- Push:
  - Accepted when iExp_Valid && !full, sampled at the cycle start.
  - A pop in the same cycle does NOT make room.
  - Push while full: data dropped, oOverflow=1, oGood=0.
  - Pushes are still accepted in HALT.
- Compare (RUN only):
  - When iDut_Valid && !empty: pop the head and compare iDut_Data == head.
  - Result is registered; oMatch/oMismatch assert exactly 1 cycle after the iDut_Valid cycle, for one cycle.
  - Counters and oGood update on that same edge.
  - No bypass: with the FIFO empty, a push and an iDut_Valid in the same cycle give oUnderflow=1, oGood=0, no compare, and the pushed entry is retained.
  - Simultaneous push and pop with the FIFO neither empty nor full: occupancy unchanged.
- In HALT: iDut_Valid is ignored; no pops, pulses or counter changes.
- Counters saturate at 2^CNT_W-1; no wrap.
- First-failure capture:
  - On the first mismatch since reset/clear, load oFirst_Exp/oFirst_Got.
  - Later mismatches do not overwrite them.
- FIFO pointers wrap modulo DEPTH. full is oPending==DEPTH; empty is oPending==0.
- oExp_Ready = !full, registered consistently with oPending. It is not a combinational path from the valid inputs.

Test Plan:
- Reset low for 2 cycles, then high → oGood=1, oExp_Ready=1, oPending=0, both counts 0, all flags 0.
- Push 3,7,12; then DUT 3,7,12 on consecutive cycles → three oMatch pulses, each 1 cycle after its DUT valid; oPass_Count=3, oPending=0, oGood=1.
- STOP_ON_FAIL=1: push 5,9; DUT 6 → oMismatch pulse, oFail_Count=1, oFirst_Exp=5, oFirst_Got=6, oHalted=1, oGood=0. DUT 9 next → ignored, oPending stays 1. iClear → oPending=0, oHalted=0, oGood=1.
- DEPTH=8: 9 consecutive pushes with no DUT traffic → oPending=8, oExp_Ready=0, oOverflow=1, 9th value lost. Then 8 matching DUT results → oPass_Count=8.
- FIFO empty, push 4 and DUT 4 in the same cycle → oUnderflow=1, no compare pulse, oPending=1. Next cycle DUT 4 → oMatch, oPass_Count=1.
- CNT_W=4, STOP_ON_FAIL=0: 20 mismatches → oFail_Count saturates at 15; oFirst_* hold the first pair. Pull Reset low mid-stream → all outputs return to reset values on the next edge.
